// File: rtl/adc_capture_pkg.sv
// Shared definitions for the multi-channel serial ADC capture engine.
package adc_capture_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StStore
    } state_t;

    localparam int unsigned DefNumCh     = 2;
    localparam int unsigned DefDataW     = 12;
    localparam int unsigned DefFrameBits = 16;
    localparam int unsigned DefClkDiv    = 4;
    localparam int unsigned DefSampleDiv = 1000;
    localparam int unsigned DefFifoDepth = 16;

    // Width of an occupancy counter able to hold 0..depth inclusive
    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port and a one-cycle read-valid strobe.
// A write into a full FIFO is accepted only when a read frees a slot in the same cycle;
// a read on an empty FIFO is ignored even if a write lands that cycle (no fall-through).
module sync_fifo
    import adc_capture_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = DefFifoDepth
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic                      i_rd_en,
    output logic [WIDTH-1:0]          o_rd_data,
    output logic                      o_rd_valid,
    output logic [count_w(DEPTH)-1:0] o_count,
    output logic                      o_full,
    output logic                      o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_do_rd = i_rd_en & ~o_empty;
    assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

    // Storage array, no reset needed
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and read port; pointers wrap naturally (DEPTH is a power of 2)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_do_rd;
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_wr && w_do_rd) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_count    = r_count;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Multi-channel serial ADC capture: generates a shared CS_n/SCLK frame at a fixed sample
// rate, deserialises NUM_CH data lines MSB first and queues channel-packed words in a FIFO.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int unsigned NUM_CH     = DefNumCh,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned FRAME_BITS = DefFrameBits,
    parameter int unsigned CLK_DIV    = DefClkDiv,
    parameter int unsigned SAMPLE_DIV = DefSampleDiv,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic                         mclk,
    input  logic                         rst,
    input  logic                         enable,
    output logic                         adc_cs_n,
    output logic                         adc_sclk,
    input  logic [NUM_CH-1:0]            adc_sdata,
    input  logic                         rd_en,
    output logic [NUM_CH*DATA_W-1:0]     rd_data,
    output logic                         rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned BIT_W  = $clog2(FRAME_BITS + 1);
    localparam int unsigned RATE_W = $clog2(SAMPLE_DIV);
    localparam int unsigned WORD_W = NUM_CH * DATA_W;

    state_t                         r_state;
    state_t                         w_state_d;
    logic [RATE_W-1:0]              r_rate_cnt;
    logic [DIV_W-1:0]               r_div;
    logic [DIV_W-1:0]               w_div_d;
    logic [BIT_W-1:0]               r_bit;
    logic [BIT_W-1:0]               w_bit_d;
    logic                           r_cs_n;
    logic                           w_cs_n_d;
    logic                           r_sclk;
    logic                           w_sclk_d;
    logic                           w_sample;
    logic                           w_wr_en;
    logic                           w_div_end;
    // Only the newest DATA_W bits of each frame survive the shift
    logic [NUM_CH-1:0][DATA_W-1:0]  r_shift;
    logic [WORD_W-1:0]              w_wr_data;
    logic                           w_fifo_full;
    logic                           w_fifo_empty;
    logic                           w_drop;
    logic                           r_overflow;

    assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_wr_data = r_shift;

    // Sample-rate counter: free-runs while enabled, parked at 0 otherwise
    always_ff @(posedge mclk) begin
        if (rst || !enable) begin
            r_rate_cnt <= '0;
        end else if (r_rate_cnt == RATE_W'(SAMPLE_DIV - 1)) begin
            r_rate_cnt <= '0;
        end else begin
            r_rate_cnt <= r_rate_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and frame-timing decode
    always_comb begin
        w_state_d = r_state;
        w_cs_n_d  = r_cs_n;
        w_sclk_d  = r_sclk;
        w_div_d   = r_div;
        w_bit_d   = r_bit;
        w_sample  = 1'b0;
        w_wr_en   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (enable && (r_rate_cnt == '0)) begin
                    w_state_d = StSetup;
                    w_cs_n_d  = 1'b0;
                    w_sclk_d  = 1'b1;
                    w_div_d   = '0;
                    w_bit_d   = '0;
                end
            end
            StSetup: begin
                if (w_div_end) begin
                    w_state_d = StShift;
                    w_sclk_d  = 1'b0;
                    w_div_d   = '0;
                end else begin
                    w_div_d = r_div + 1'b1;
                end
            end
            StShift: begin
                if (w_div_end) begin
                    w_div_d = '0;
                    if (!r_sclk) begin
                        w_sclk_d = 1'b1;
                        w_sample = 1'b1;
                        w_bit_d  = r_bit + 1'b1;
                    end else if (r_bit == BIT_W'(FRAME_BITS)) begin
                        // Last high half-period done; sclk stays high into STORE
                        w_state_d = StStore;
                    end else begin
                        w_sclk_d = 1'b0;
                    end
                end else begin
                    w_div_d = r_div + 1'b1;
                end
            end
            StStore: begin
                w_wr_en   = 1'b1;
                w_cs_n_d  = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Serial interface registers and per-channel shift registers
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b1;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_cs_n <= w_cs_n_d;
            r_sclk <= w_sclk_d;
            r_div  <= w_div_d;
            r_bit  <= w_bit_d;
            if (w_sample) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_shift[c] <= {r_shift[c][DATA_W-2:0], adc_sdata[c]};
                end
            end
        end
    end

    // A store is dropped only if the FIFO is full and no pop frees a slot this cycle
    assign w_drop = w_wr_en & w_fifo_full & ~(rd_en & ~w_fifo_empty);

    // Sticky overflow flag; a new drop beats a same-cycle clear
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (mclk),
        .i_rst      (rst),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (w_wr_data),
        .i_rd_en    (rd_en),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_count    (fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign adc_cs_n = r_cs_n;
    assign adc_sclk = r_sclk;
    assign overflow = r_overflow;

endmodule
